cdc_hs_src: RTL and testbench



---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_sync_bit.sv | 23 ++
 rtl/cdc_hs_src.sv | 125 ++++++++++++
 tb/tb_cdc_hs_src.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and limits for the req/ack clock-domain-crossing link.
package cdc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitHi,
    StWaitLo
  } hs_state_e;

  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 4;

  // Watchdog counter width; a disabled watchdog still gets one (unused) bit.
  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous reset to 0.
module cdc_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_src.sv
// Source end of a four-phase req/ack CDC link with a per-edge watchdog.
module cdc_hs_src
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);
  localparam bit WdEn = (TIMEOUT_CYC != 0);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : gen_sync_check
    $error("cdc_hs_src: SYNC_STAGES out of range 2..4");
  end

  hs_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              err_q, err_d;
  logic              err_set;
  logic              expire;
  logic              ack_s;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (xfer_ack),
    .q    (ack_s)
  );

  // Saturating increment; expiry is when the incremented count hits the limit.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign expire  = WdEn && (cnt_inc == CntMax);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          data_d  = s_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWaitLo;
        end else if (expire) begin
          req_d   = 1'b0;
          cnt_d   = cnt_inc;
          err_set = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitLo: begin
        if (!ack_s) begin
          state_d = StIdle;
        end else if (expire) begin
          req_d   = 1'b0;
          cnt_d   = cnt_inc;
          err_set = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
    // Set has priority over clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign s_ready     = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Directed bench for cdc_hs_src against a cycle-level behavioural model.
module tb_cdc_hs_src;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack;
  logic          busy;
  logic          err_timeout;
  logic          err_clr;

  logic man_ack;
  logic resp_ack;
  logic resp_en;
  assign xfer_ack = resp_en ? resp_ack : man_ack;

  int checks = 0;
  int errors = 0;

  cdc_hs_src #(
    .DATA_W     (DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_ack   (xfer_ack),
    .busy       (busy),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: phase 0 idle, 1 awaiting ack high, 2 awaiting ack low.
  // The destination ack is seen SYNC edges after it is sampled.
  int            m_phase = 0;
  int            m_wait = 0;
  logic          m_req = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_err = 1'b0;
  logic          m_hist [SYNC];
  logic          m_ack_s = 1'b0;
  bit            m_live = 1'b0;

  always @(posedge clk) begin : model
    int            ph;
    int            w;
    logic          rq;
    logic [DW-1:0] dt;
    logic          er;
    logic          seen;
    logic          set;
    logic          h [SYNC];
    ph = m_phase; w = m_wait; rq = m_req; dt = m_data; er = m_err;
    for (int i = 0; i < SYNC; i++) h[i] = m_hist[i];
    if (!rst_n) begin
      ph = 0; w = 0; rq = 1'b0; dt = '0; er = 1'b0;
      for (int i = 0; i < SYNC; i++) h[i] = 1'b0;
    end else begin
      seen = h[0];
      set  = 1'b0;
      case (ph)
        0: if (s_valid) begin
          dt = s_data; rq = 1'b1; w = 0; ph = 1;
        end
        1: if (seen) begin
          rq = 1'b0; w = 0; ph = 2;
        end else if (w + 1 >= TO) begin
          rq = 1'b0; set = 1'b1; ph = 0;
        end else begin
          w++;
        end
        default: if (!seen) begin
          ph = 0;
        end else if (w + 1 >= TO) begin
          rq = 1'b0; set = 1'b1; ph = 0;
        end else begin
          w++;
        end
      endcase
      er = set ? 1'b1 : (err_clr ? 1'b0 : er);
      for (int i = 0; i < SYNC - 1; i++) h[i] = h[i+1];
      h[SYNC-1] = xfer_ack;
    end
    m_phase <= ph; m_wait <= w; m_req <= rq; m_data <= dt; m_err <= er;
    for (int i = 0; i < SYNC; i++) m_hist[i] <= h[i];
    m_ack_s <= h[0];
    m_live  <= 1'b1;
  end

  bit            stab_en = 1'b0;
  logic          p_req = 1'b0;
  logic          p_acks = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_s_ready", DW'(s_ready), DW'(m_phase == 0));
      chk("m_busy", DW'(busy), DW'(m_phase != 0));
      chk("m_xfer_req", DW'(xfer_req), DW'(m_req));
      chk("m_xfer_data", xfer_data, m_data);
      chk("m_err_timeout", DW'(err_timeout), DW'(m_err));
      if (stab_en && (p_req || p_acks)) chk("data_stable", xfer_data, p_data);
      p_req  <= xfer_req;
      p_acks <= m_ack_s;
      p_data <= xfer_data;
    end
  end

  // Auto-responding destination with random 1..7 cycle delays.
  logic [DW-1:0] rcv [16];
  int            rcv_n = 0;

  initial begin : responder
    int d;
    int k;
    resp_ack = 1'b0;
    forever begin
      step();
      if (resp_en && xfer_req && !resp_ack) begin
        d = $urandom_range(1, 7);
        repeat (d) step();
        if (rcv_n < 16) rcv[rcv_n] = xfer_data;
        rcv_n++;
        resp_ack = 1'b1;
        k = 0;
        while (xfer_req && k < 40) begin
          step();
          k++;
        end
        if (k >= 40) chk("resp_req_fall_timeout", DW'(k), 32'd0);
        d = $urandom_range(1, 7);
        repeat (d) step();
        resp_ack = 1'b0;
      end
    end
  end

  task automatic accept(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic send(input int n, input logic [DW-1:0] first);
    int   idx;
    int   k;
    logic rdy;
    idx = 0; k = 0;
    s_valid = 1'b1;
    s_data  = first;
    while (idx < n && k < 400) begin
      rdy = s_ready;
      step();
      k++;
      if (rdy) begin
        idx++;
        s_data = first + DW'(idx);
        if (idx == n) s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk("send_accept_bound", DW'(idx), DW'(n));
  endtask

  initial begin : main
    int n;
    int base;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    man_ack = 1'b0; resp_en = 1'b0;
    repeat (3) step();
    chk("rst_s_ready", DW'(s_ready), 32'd1);
    chk("rst_xfer_req", DW'(xfer_req), 32'd0);
    chk("rst_xfer_data", xfer_data, 32'd0);
    chk("rst_busy", DW'(busy), 32'd0);
    chk("rst_err", DW'(err_timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // Single word, manual ack.
    accept(32'hDEADBEEF);
    chk("sw_req_rise", DW'(xfer_req), 32'd1);
    chk("sw_data", xfer_data, 32'hDEADBEEF);
    chk("sw_s_ready_low", DW'(s_ready), 32'd0);
    repeat (5) step();
    man_ack = 1'b1;
    for (n = 1; n <= 20; n++) begin
      step();
      if (!xfer_req) break;
    end
    chk("sw_req_fall_latency", DW'(n), 32'd3);
    man_ack = 1'b0;
    for (n = 1; n <= 20; n++) begin
      step();
      if (s_ready) break;
    end
    chk("sw_ready_latency", DW'(n), 32'd3);
    chk("sw_data_kept", xfer_data, 32'hDEADBEEF);

    // Back-to-back with the auto-responder.
    resp_en = 1'b1;
    stab_en = 1'b1;
    base = rcv_n;
    send(3, 32'h1);
    n = 0;
    while ((rcv_n < base + 3 || busy || resp_ack) && n < 300) begin
      step();
      n++;
    end
    chk("b2b_done_bound", DW'(n < 300), 32'd1);
    chk("b2b_count", DW'(rcv_n - base), 32'd3);
    for (int i = 0; i < 3; i++) chk("b2b_word", rcv[(base + i) % 16], DW'(i + 1));
    stab_en = 1'b0;
    resp_en = 1'b0;
    step();

    // Timeout with no ack.
    accept(32'h0000A5A5);
    for (n = 1; n <= 30; n++) begin
      step();
      if (err_timeout) break;
    end
    chk("to_cycle", DW'(n), 32'd16);
    chk("to_req_low", DW'(xfer_req), 32'd0);
    chk("to_s_ready", DW'(s_ready), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_cleared", DW'(err_timeout), 32'd0);

    // Stuck ack.
    accept(32'h5A);
    man_ack = 1'b1;
    for (n = 1; n <= 20; n++) begin
      step();
      if (!xfer_req) break;
    end
    chk("stuck_req_fall", DW'(n), 32'd3);
    for (n = 1; n <= 30; n++) begin
      step();
      if (err_timeout) break;
    end
    chk("stuck_to_cycle", DW'(n), 32'd16);
    chk("stuck_busy", DW'(busy), 32'd0);
    man_ack = 1'b0;
    repeat (4) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("stuck_err_cleared", DW'(err_timeout), 32'd0);

    // Expiry and clear on the same edge.
    accept(32'h33);
    repeat (15) step();
    chk("svc_err_before", DW'(err_timeout), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("svc_set_wins", DW'(err_timeout), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("svc_clear_after", DW'(err_timeout), 32'd0);

    // Reset mid-transfer, then a normal word.
    accept(32'h77);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("mrst_req", DW'(xfer_req), 32'd0);
    chk("mrst_data", xfer_data, 32'd0);
    chk("mrst_busy", DW'(busy), 32'd0);
    chk("mrst_s_ready", DW'(s_ready), 32'd1);
    rst_n = 1'b1;
    step();
    resp_en = 1'b1;
    base = rcv_n;
    send(1, 32'h99);
    n = 0;
    while ((rcv_n < base + 1 || busy || resp_ack) && n < 200) begin
      step();
      n++;
    end
    chk("mrst_word", rcv[base % 16], 32'h99);
    chk("mrst_no_err", DW'(err_timeout), 32'd0);
    resp_en = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global time limit");
  end

endmodule
